// File: rtl/inst_queue_pkg.sv
// Shared widths and entry layout for the instruction queue between fetch and dispatch.
package inst_queue_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int IQ_INDEX_WIDTH = 4;
    localparam int IQ_SIZE        = 1 << IQ_INDEX_WIDTH;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  predicted_to_jump;
        logic [ADDR_WIDTH-1:0] predicted_pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer with show-ahead head, early-full throttle for the fetcher,
// and a roll-back flush that also squashes the fetcher's one stale in-flight instruction.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_ADDR_WIDTH = IQ_INDEX_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     IF_input_valid,
    input  logic [INST_WIDTH-1:0]    IF_inst,
    input  logic [ADDR_WIDTH-1:0]    IF_inst_pc,
    input  logic                     IF_predicted_to_jump,
    input  logic [ADDR_WIDTH-1:0]    IF_predicted_pc,
    output logic                     IF_is_full,
    input  logic                     ID_ready,
    output logic                     ID_output_valid,
    output logic [INST_WIDTH-1:0]    ID_inst,
    output logic [ADDR_WIDTH-1:0]    ID_inst_pc,
    output logic                     ID_predicted_to_jump,
    output logic [ADDR_WIDTH-1:0]    ID_predicted_pc,
    input  logic                     ROB_roll_back_flag,
    output logic [IQ_ADDR_WIDTH:0]   dbg_count,
    output logic                     dbg_squash
);

    // Handshake: an entry moves to dispatch on an edge where ID_output_valid & ID_ready & rdy;
    // the fetcher's IF_input_valid is a push request that is only honoured when not full/squashed.

    localparam int DEPTH = 1 << IQ_ADDR_WIDTH;
    localparam logic [IQ_ADDR_WIDTH:0] CNT_FULL      = (IQ_ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IQ_ADDR_WIDTH:0] CNT_NEAR_FULL = (IQ_ADDR_WIDTH+1)'(DEPTH - 1);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic                  pj_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] ppc_mem  [DEPTH];

    logic [IQ_ADDR_WIDTH-1:0] head;
    logic [IQ_ADDR_WIDTH-1:0] tail;
    logic [IQ_ADDR_WIDTH:0]   count;
    logic                     squash;
    logic                     push;
    logic                     pop;
    iq_entry_t                head_entry;

    assign push = IF_input_valid & rdy & ~ROB_roll_back_flag & ~squash & (count != CNT_FULL);
    assign pop  = ID_output_valid & ID_ready & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            squash <= 1'b0;
        end else if (rdy) begin
            // squash covers exactly the cycle after each flagged cycle
            squash <= ROB_roll_back_flag;
            if (ROB_roll_back_flag) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is never reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= IF_inst;
            pc_mem[tail]   <= IF_inst_pc;
            pj_mem[tail]   <= IF_predicted_to_jump;
            ppc_mem[tail]  <= IF_predicted_pc;
        end
    end

    always_comb begin
        head_entry = '0;
        if (ID_output_valid) begin
            head_entry.inst              = inst_mem[head];
            head_entry.pc                = pc_mem[head];
            head_entry.predicted_to_jump = pj_mem[head];
            head_entry.predicted_pc      = ppc_mem[head];
        end
    end

    assign ID_output_valid      = (count != '0) & ~ROB_roll_back_flag & rdy;
    assign ID_inst              = head_entry.inst;
    assign ID_inst_pc           = head_entry.pc;
    assign ID_predicted_to_jump = head_entry.predicted_to_jump;
    assign ID_predicted_pc      = head_entry.predicted_pc;

    // One slot of slack absorbs the instruction the fetcher already has registered.
    assign IF_is_full = (count >= CNT_NEAR_FULL);
    assign dbg_count  = count;
    assign dbg_squash = squash;

endmodule
